roi_apb_master: RTL and testbench
=================================

Name: roi_apb_master

Overview:
- APB requester (initiator) that drives the ROI register-file completer; it is the opposite end of the ROI APB link.
- Converts a single-beat valid/ready command (addr, write, wdata) into a standard two-phase APB transfer (SETUP, then ACCESS), and waits for PREADY.
- Returns read data and status on a valid/ready response channel.
- Sits between the ROI control sequencer and the ROI APB completer that holds the XY0/XY1 coordinates.

Parameters:
- APB_DATA_W, 32, PWDATA/PRDATA and command data width
- APB_ADDR_W, 12, PADDR and command address width
- TIMEOUT_CYC, 16, maximum ACCESS cycles before abort (used only with the optional feature); must be ≥2

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset, synchronous, active-high (sampled on posedge clk_i only)
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  APB_ADDR_W  target address
- cmd_wdata_i  in  APB_DATA_W  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  APB_DATA_W  read data (0 for writes)
- rsp_timeout_o  out  1  transfer aborted by timeout (tied 0 without the feature)
- apb_psel_o  out  1  PSEL
- apb_penable_o  out  1  PENABLE
- apb_pwrite_o  out  1  PWRITE
- apb_paddr_o  out  APB_ADDR_W  PADDR
- apb_pwdata_o  out  APB_DATA_W  PWDATA
- apb_pready_i  in  1  PREADY
- apb_prdata_i  in  APB_DATA_W  PRDATA

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Reset (arst_i high at a posedge):
  - state goes to IDLE.
  - All outputs are 0 except cmd_ready_o, which is 1 (IDLE).
  - This applies mid-transfer too: PSEL/PENABLE drop on the same edge, and any pending response is discarded.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, register addr, write and wdata, then go to SETUP.
- SETUP (exactly 1 cycle):
  - psel = 1, penable = 0, with paddr/pwrite/pwdata driven from the registered command.
  - Go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; addr, write and data are held stable.
  - On the edge where apb_pready_i = 1:
    - Read: capture apb_prdata_i into rsp_rdata_o.
    - Write: rsp_rdata_o = 0.
    - rsp_timeout_o = 0; go to RESP.
  - PREADY is ignored outside ACCESS.
- RESP:
  - psel = penable = 0, rsp_valid_o = 1.
  - Response fields are held until rsp_ready_i; then go to IDLE.
- cmd_ready_o is high only in IDLE, so at most one transfer is outstanding.
- Minimum command-to-response latency: accept edge, then SETUP 1 cycle, then ACCESS of N cycles (N ≥ 1, set by PREADY), then RESP.
- Against the ROI completer (registered PREADY), N = 2, so rsp_valid_o rises 4 cycles after acceptance.
- Back-to-back: if rsp_ready_i is already high when RESP is entered, RESP lasts 1 cycle; the next command is accepted in the following IDLE cycle.
- apb_paddr_o, apb_pwrite_o and apb_pwdata_o hold their last values when idle; they are only required to be valid while psel = 1.

Optional Feature:
- Macro: ROI_APB_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to ACCESS and increments each ACCESS cycle without PREADY.
  - When the count reaches TIMEOUT_CYC - 1 without PREADY: leave ACCESS, go to RESP with rsp_timeout_o = 1 and rsp_rdata_o = 0, and drop PSEL.
  - If PREADY arrives on that same final cycle, it wins: normal completion with timeout = 0.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - rsp_timeout_o is tied 0.

Decomposition:
- Package roi_apb_pkg holds:
  - the FSM state enum;
  - ADDR_XY_0 = 12'h0 and ADDR_XY_1 = 12'h4;
  - the default widths.
- No sub-module; the timeout counter stays inline in roi_apb_master.

Test Plan:
- Write 0x0012_0034 to 0x0 against the ROI completer: SETUP 1 cycle, ACCESS 2 cycles, PSEL/PENABLE/PWRITE/PADDR/PWDATA correct; rsp_valid_o 4 cycles after accept, rsp_rdata_o = 0, timeout = 0.
- Read 0x4 with the completer model returning 0xDEAD_BEEF, PREADY delayed 5 cycles: ACCESS lasts 5 cycles with stable signals; rsp_rdata_o = 0xDEAD_BEEF.
- Backpressure: hold rsp_ready_i = 0 for 3 cycles: rsp_valid_o and rsp_rdata_o stay stable, cmd_ready_o = 0, and no new PSEL is issued.
- Reset: assert arst_i in the second ACCESS cycle: next edge psel = penable = 0, rsp_valid_o = 0, cmd_ready_o = 1; a new read then completes normally.
- With ROI_APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 4, PREADY never asserted: ACCESS lasts exactly 4 cycles, then rsp_valid_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
- With ROI_APB_MASTER_TIMEOUT_EN, PREADY on the 4th ACCESS cycle: normal completion with rsp_timeout_o = 0 and data captured.

Source files
------------

// File: rtl/roi_apb_pkg.sv
// Shared types and constants for the ROI APB link: requester FSM states,
// ROI completer register map and default bus widths.
package roi_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    localparam logic [11:0] ADDR_XY_0 = 12'h0;
    localparam logic [11:0] ADDR_XY_1 = 12'h4;

    localparam int APB_DATA_W_DEF  = 32;
    localparam int APB_ADDR_W_DEF  = 12;
    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/roi_apb_master.sv
// APB requester for the ROI register file: one valid/ready command becomes one
// SETUP+ACCESS transfer. Define ROI_APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
module roi_apb_master
    import roi_apb_pkg::*;
#(
    parameter int APB_DATA_W  = APB_DATA_W_DEF,
    parameter int APB_ADDR_W  = APB_ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [APB_ADDR_W-1:0] cmd_addr_i,
    input  logic [APB_DATA_W-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [APB_DATA_W-1:0] rsp_rdata_o,
    output logic                  rsp_timeout_o,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [APB_ADDR_W-1:0] apb_paddr_o,
    output logic [APB_DATA_W-1:0] apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic [APB_DATA_W-1:0] apb_prdata_i
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("roi_apb_master: TIMEOUT_CYC must be >= 2");
    end

    apb_state_e state;
    apb_state_e state_next;

    logic                  write_q;
    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_DATA_W-1:0] rdata_q;
    logic                  timeout_hit;

`ifdef ROI_APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // PREADY on the final cycle still completes normally; timeout_hit only matters without it
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            cnt <= '0;
        end else if (state == ST_SETUP) begin
            cnt <= '0;
        end else if (state == ST_ACCESS && !apb_pready_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            timeout_q <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (apb_pready_i) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_valid_i) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (apb_pready_i || timeout_hit) state_next = ST_RESP;
            ST_RESP:   if (rsp_ready_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid_i) begin
                write_q <= cmd_write_i;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
            end
            if (state == ST_ACCESS) begin
                if (apb_pready_i) begin
                    rdata_q <= write_q ? '0 : apb_prdata_i;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                end
            end
        end
    end

    assign cmd_ready_o   = (state == ST_IDLE);
    assign apb_psel_o    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign apb_penable_o = (state == ST_ACCESS);
    assign apb_pwrite_o  = write_q;
    assign apb_paddr_o   = addr_q;
    assign apb_pwdata_o  = wdata_q;
    assign rsp_valid_o   = (state == ST_RESP);
    assign rsp_rdata_o   = rdata_q;

endmodule

// File: tb/tb_roi_apb_master.sv
// Scoreboard bench for roi_apb_master with a PREADY-delay completer model;
// timeout vectors run when ROI_APB_MASTER_TIMEOUT_EN is defined.
module tb_roi_apb_master;
    import roi_apb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata;

    always #5 clk = ~clk;

    roi_apb_master #(
        .APB_DATA_W (DW),
        .APB_ADDR_W (AW),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_timeout_o(rsp_timeout),
        .apb_psel_o   (psel),
        .apb_penable_o(penable),
        .apb_pwrite_o (pwrite),
        .apb_paddr_o  (paddr),
        .apb_pwdata_o (pwdata),
        .apb_pready_i (pready),
        .apb_prdata_i (prdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          timeout;
    } rsp_t;

    rsp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completer model: PREADY rises on ACCESS cycle m_delay (0 = never)
    int            m_delay = 2;
    logic [DW-1:0] m_rdata = '0;
    int            acc_cyc = 0;

    assign prdata = m_rdata;

    always @(negedge clk) begin
        if (psel && penable) acc_cyc = acc_cyc + 1;
        else                 acc_cyc = 0;
        pready = (m_delay != 0) && (acc_cyc == m_delay);
    end

    // Response monitor: pops one expectation per completed handshake
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!arst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %h with no expected response", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.timeout});
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        int guard;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = (hold == 0);
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int delay, input logic [DW-1:0] rd_model,
                        input logic [DW-1:0] exp_rd, input logic exp_to,
                        input int exp_alen, input int hold);
        int lat;
        int alen;
        m_delay = delay;
        m_rdata = rd_model;
        issue(w, a, d, hold);
        exp_q.push_back('{exp_rd, exp_to});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        chk("setup_psel", {31'b0, psel}, 32'd1);
        chk("setup_penable", {31'b0, penable}, 32'd0);
        chk("setup_pwrite", {31'b0, pwrite}, {31'b0, w});
        chk("setup_paddr", {20'b0, paddr}, {20'b0, a});
        chk("setup_pwdata", pwdata, d);
        alen = 0;
        while (alen < 64) begin
            @(negedge clk);
            lat++;
            if (!(psel && penable)) break;
            alen++;
            chk("access_paddr", {20'b0, paddr}, {20'b0, a});
            chk("access_pwrite", {31'b0, pwrite}, {31'b0, w});
            chk("access_pwdata", pwdata, d);
        end
        chk("access_len", alen, exp_alen);
        chk("latency", lat, exp_alen + 2);
        chk("resp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("resp_psel", {31'b0, psel}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, exp_rd);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("bp_psel", {31'b0, psel}, 32'd0);
            if (i < hold - 1) @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_paddr", {20'b0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        @(posedge clk);
        #1 arst = 1'b0;

        // ROI completer timing: write XY0, ACCESS 2 cycles, response after 4
        xfer(1'b1, ADDR_XY_0, 32'h0012_0034, 2, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 0);
        // slow read of XY1
        xfer(1'b0, ADDR_XY_1, 32'h0, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 5, 0);
        // response backpressure for 3 cycles
        xfer(1'b0, ADDR_XY_0, 32'h0, 2, 32'h0012_0034, 32'h0012_0034, 1'b0, 2, 3);
        // shortest ACCESS, write returns zero data
        xfer(1'b1, ADDR_XY_1, 32'h00AB_00CD, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 0);

        // reset in the second ACCESS cycle
        m_delay = 5;
        m_rdata = 32'h1111_2222;
        issue(1'b0, ADDR_XY_1, 32'h0, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_access1", {31'b0, penable}, 32'd1);
        @(posedge clk);
        #1 arst = 1'b1;
        @(negedge clk);
        chk("rstmid_access2", {31'b0, penable}, 32'd1);
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("rstmid_psel", {31'b0, psel}, 32'd0);
        chk("rstmid_penable", {31'b0, penable}, 32'd0);
        chk("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rstmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        xfer(1'b0, ADDR_XY_1, 32'h0, 2, 32'h0056_0078, 32'h0056_0078, 1'b0, 2, 0);

`ifdef ROI_APB_MASTER_TIMEOUT_EN
        // PREADY never arrives: abort after 4 ACCESS cycles
        xfer(1'b0, ADDR_XY_1, 32'h0, 0, 32'hDEAD_BEEF, 32'h0, 1'b1, 4, 0);
        // PREADY on the final cycle wins over the timeout
        xfer(1'b0, ADDR_XY_0, 32'h0, 4, 32'h1234_5678, 32'h1234_5678, 1'b0, 4, 0);
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
